// File: rtl/fsmc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsmc_pkg
//  Purpose  : Shared constants for the FSMC multiplexed-bus master: state
//             encoding, address/data widths, phase-counter width and the
//             default timing values.
//  Revision : 1.0  initial release
// ============================================================================
package fsmc_pkg;

    localparam int c_ADDR_W = 19;                  // full external address
    localparam int c_AD_W   = 16;                  // multiplexed AD bus
    localparam int c_AHI_W  = c_ADDR_W - c_AD_W;   // A16..A18
    localparam int c_CNT_W  = 8;                   // phase counter width

    localparam int c_DEF_ADDSET  = 2;
    localparam int c_DEF_ADDHLD  = 1;
    localparam int c_DEF_DATAST  = 4;
    localparam int c_DEF_BUSTURN = 1;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_ASET = 3'd1;
    localparam logic [2:0] c_S_AHLD = 3'd2;
    localparam logic [2:0] c_S_DATA = 3'd3;
    localparam logic [2:0] c_S_ENDC = 3'd4;
    localparam logic [2:0] c_S_TURN = 3'd5;

    // Counter load value for a phase of 'len' cycles; a phase ends when the
    // counter reads zero, so a phase of N cycles loads N-1.
    function automatic logic [c_CNT_W-1:0] phase_load(input int len);
        return (len > 0) ? c_CNT_W'(len - 1) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsmc_mux_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsmc_mux_master_if
//  Purpose  : Bundles the host request/response signals and the multiplexed
//             FSMC pad-side signals of the master.
//  Signals  : req/wr/addr/wdata      host request (into master)
//             busy/ack/rdata         host response (from master)
//             ne/nadv/noe/nwe        active-low bus strobes (from master)
//             a_hi/ad_out/ad_oe      address high bits, AD drive, AD enable
//             ad_in                  AD value read back from the pad
//  Modports : master - the bus master block
//             slave  - the host plus the far end of the bus
//  Revision : 1.0  initial release
// ============================================================================
interface fsmc_mux_master_if;
    import fsmc_pkg::*;

    logic                req;
    logic                wr;
    logic [c_ADDR_W-1:0] addr;
    logic [c_AD_W-1:0]   wdata;
    logic                busy;
    logic                ack;
    logic [c_AD_W-1:0]   rdata;
    logic                ne;
    logic                nadv;
    logic                noe;
    logic                nwe;
    logic [c_AHI_W-1:0]  a_hi;
    logic [c_AD_W-1:0]   ad_out;
    logic                ad_oe;
    logic [c_AD_W-1:0]   ad_in;

    modport master (
        input  req, wr, addr, wdata, ad_in,
        output busy, ack, rdata, ne, nadv, noe, nwe, a_hi, ad_out, ad_oe
    );

    modport slave (
        output req, wr, addr, wdata, ad_in,
        input  busy, ack, rdata, ne, nadv, noe, nwe, a_hi, ad_out, ad_oe
    );

endinterface
`default_nettype wire

// File: rtl/fsmc_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : fsmc_phase_cnt
//  Purpose  : Phase-length down counter. Loaded with (length-1) on phase
//             entry, counts down to zero and stops there.
//  Ports    : clk, rst_n      clock, synchronous active-low reset
//             i_load          load strobe (phase entry)
//             i_load_val      value to load
//             o_zero          counter is zero (last cycle of the phase)
//  Revision : 1.0  initial release
// ============================================================================
module fsmc_phase_cnt
    import fsmc_pkg::*;
(
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_load,
    input  wire [c_CNT_W-1:0]  i_load_val,
    output logic               o_zero
);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fsmc_mux_master.sv
`default_nettype none
// ============================================================================
//  Module   : fsmc_mux_master
//  Purpose  : Master for an FSMC-style multiplexed address/data bus.
//             Sequence: IDLE -> ASET -> AHLD -> DATA -> ENDC -> [TURN] -> IDLE
//  Ports    : clk        sole clock
//             rst_n      synchronous active-low reset
//             bus        fsmc_mux_master_if.master (host + pad signals)
//  Params   : ADDSET (1..15), ADDHLD (1..15), DATAST (1..255), BUSTURN (0..15)
//  Revision : 1.0  initial release
// ============================================================================
module fsmc_mux_master
    import fsmc_pkg::*;
#(
    parameter int ADDSET  = c_DEF_ADDSET,
    parameter int ADDHLD  = c_DEF_ADDHLD,
    parameter int DATAST  = c_DEF_DATAST,
    parameter int BUSTURN = c_DEF_BUSTURN
) (
    input  wire                clk,
    input  wire                rst_n,
    fsmc_mux_master_if.master  bus
);

    localparam logic [c_CNT_W-1:0] c_LD_ASET = phase_load(ADDSET);
    localparam logic [c_CNT_W-1:0] c_LD_AHLD = phase_load(ADDHLD);
    localparam logic [c_CNT_W-1:0] c_LD_DATA = phase_load(DATAST);
    localparam logic [c_CNT_W-1:0] c_LD_ENDC = phase_load(1);
    localparam logic [c_CNT_W-1:0] c_LD_TURN = phase_load(BUSTURN);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                r_rdy;       // set once the first post-reset edge has passed
    logic                r_wr;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_AD_W-1:0]   r_wdata;

    logic                w_accept;
    logic                w_zero;
    logic                w_load;
    logic [c_CNT_W-1:0]  w_load_val;

    // Values that will be current after this edge: on the accept edge the
    // capture registers are not yet loaded, so use the inputs directly.
    logic                w_wr;
    logic [c_ADDR_W-1:0] w_addr;
    logic [c_AD_W-1:0]   w_wdata;

    logic                w_ne, w_nadv, w_noe, w_nwe, w_ad_oe;
    logic [c_AD_W-1:0]   w_ad_out;
    logic [c_AHI_W-1:0]  w_a_hi;

    logic                r_ne, r_nadv, r_noe, r_nwe, r_ad_oe, r_ack, r_busy;
    logic [c_AD_W-1:0]   r_ad_out;
    logic [c_AD_W-1:0]   r_rdata;
    logic [c_AHI_W-1:0]  r_a_hi;

    assign w_accept = (r_state == c_S_IDLE) && bus.req && r_rdy;
    assign w_wr     = w_accept ? bus.wr    : r_wr;
    assign w_addr   = w_accept ? bus.addr  : r_addr;
    assign w_wdata  = w_accept ? bus.wdata : r_wdata;

    fsmc_phase_cnt u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            c_S_IDLE: if (w_accept) begin
                w_state_nxt = c_S_ASET;
                w_load      = 1'b1;
                w_load_val  = c_LD_ASET;
            end
            c_S_ASET: if (w_zero) begin
                w_state_nxt = c_S_AHLD;
                w_load      = 1'b1;
                w_load_val  = c_LD_AHLD;
            end
            c_S_AHLD: if (w_zero) begin
                w_state_nxt = c_S_DATA;
                w_load      = 1'b1;
                w_load_val  = c_LD_DATA;
            end
            c_S_DATA: if (w_zero) begin
                w_state_nxt = c_S_ENDC;
                w_load      = 1'b1;
                w_load_val  = c_LD_ENDC;
            end
            c_S_ENDC: begin
                if (BUSTURN == 0) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_state_nxt = c_S_TURN;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_TURN;
                end
            end
            c_S_TURN: if (w_zero) begin
                w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every pin
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_ne     = 1'b1;
        w_nadv   = 1'b1;
        w_noe    = 1'b1;
        w_nwe    = 1'b1;
        w_ad_oe  = 1'b0;
        w_ad_out = '0;
        w_a_hi   = '0;
        case (w_state_nxt)
            c_S_ASET: begin
                w_ne     = 1'b0;
                w_nadv   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr[c_AD_W-1:0];
                w_a_hi   = w_addr[c_ADDR_W-1:c_AD_W];
            end
            c_S_AHLD: begin
                w_ne     = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr[c_AD_W-1:0];
                w_a_hi   = w_addr[c_ADDR_W-1:c_AD_W];
            end
            c_S_DATA: begin
                w_ne   = 1'b0;
                w_a_hi = w_addr[c_ADDR_W-1:c_AD_W];
                if (w_wr) begin
                    w_nwe    = 1'b0;
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_wdata;
                end else begin
                    w_noe = 1'b0;
                end
            end
            c_S_ENDC: begin
                // Write data and A_HI stay driven one cycle past the NWE rise.
                w_a_hi = w_addr[c_ADDR_W-1:c_AD_W];
                if (w_wr) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_rdy    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ne     <= 1'b1;
            r_nadv   <= 1'b1;
            r_noe    <= 1'b1;
            r_nwe    <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= '0;
            r_a_hi   <= '0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rdy    <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_accept) begin
                r_wr    <= bus.wr;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            r_ne     <= w_ne;
            r_nadv   <= w_nadv;
            r_noe    <= w_noe;
            r_nwe    <= w_nwe;
            r_ad_oe  <= w_ad_oe;
            r_ad_out <= w_ad_out;
            r_a_hi   <= w_a_hi;
            r_ack    <= (w_state_nxt == c_S_ENDC);
            r_busy   <= (w_state_nxt != c_S_IDLE);
            // Sample the pad on the edge that closes the last DATA cycle.
            if ((r_state == c_S_DATA) && w_zero && !r_wr) begin
                r_rdata <= bus.ad_in;
            end
        end
    end

    assign bus.ne     = r_ne;
    assign bus.nadv   = r_nadv;
    assign bus.noe    = r_noe;
    assign bus.nwe    = r_nwe;
    assign bus.ad_oe  = r_ad_oe;
    assign bus.ad_out = r_ad_out;
    assign bus.a_hi   = r_a_hi;
    assign bus.ack    = r_ack;
    assign bus.busy   = r_busy;
    assign bus.rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_mux_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsmc_mux_master
//  Purpose  : Directed self-checking bench for fsmc_mux_master. One instance
//             uses default timing, one uses minimum timing; a small slave
//             buffer model sits on the default instance's bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fsmc_mux_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fsmc_mux_master_if bus_d ();
    fsmc_mux_master_if bus_f ();

    fsmc_mux_master #(.ADDSET(2), .ADDHLD(1), .DATAST(4), .BUSTURN(1)) dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d.master)
    );

    fsmc_mux_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(0)) dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f.master)
    );

    // Slave buffer model: latches the address on the NADV rise, stores write
    // data on the NWE rise, drives the stored word while NOE is low.
    logic [15:0] mem [0:15];
    logic [18:0] lat_addr  = '0;
    logic        prev_nadv = 1'b1;
    logic        prev_nwe  = 1'b1;

    always @(posedge clk) begin
        prev_nadv <= bus_d.nadv;
        prev_nwe  <= bus_d.nwe;
        if (!rst_n) begin
            mem[1] <= 16'hA55A;
        end else begin
            if (!prev_nadv && bus_d.nadv) lat_addr <= {bus_d.a_hi, bus_d.ad_out};
            if (!prev_nwe && bus_d.nwe)   mem[lat_addr[3:0]] <= bus_d.ad_out;
        end
    end

    assign bus_d.ad_in = bus_d.noe ? 16'h0000 : mem[lat_addr[3:0]];
    assign bus_f.ad_in = 16'h0000;

    int ack_d = 0;
    int ack_f = 0;
    always @(posedge clk) begin
        if (bus_d.ack) ack_d <= ack_d + 1;
        if (bus_f.ack) ack_f <= ack_f + 1;
    end

    int n_run  = 0;
    int n_fail = 0;
    int a0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_d(input string p);
        chk({p, "_ne"},     bus_d.ne,     1);
        chk({p, "_nadv"},   bus_d.nadv,   1);
        chk({p, "_noe"},    bus_d.noe,    1);
        chk({p, "_nwe"},    bus_d.nwe,    1);
        chk({p, "_ad_oe"},  bus_d.ad_oe,  0);
        chk({p, "_ad_out"}, bus_d.ad_out, 0);
        chk({p, "_a_hi"},   bus_d.a_hi,   0);
        chk({p, "_ack"},    bus_d.ack,    0);
        chk({p, "_rdata"},  bus_d.rdata,  0);
        chk({p, "_busy"},   bus_d.busy,   0);
    endtask

    task automatic start_d(input logic w, input logic [18:0] a, input logic [15:0] d);
        bus_d.req   = 1'b1;
        bus_d.wr    = w;
        bus_d.addr  = a;
        bus_d.wdata = d;
        tick();
        bus_d.req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_d.req = 1'b0; bus_d.wr = 1'b0; bus_d.addr = '0; bus_d.wdata = '0;
        bus_f.req = 1'b0; bus_f.wr = 1'b0; bus_f.addr = '0; bus_f.wdata = '0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick(); tick();
        chk_reset_d("rst");
        chk("rst_f_busy", bus_f.busy, 0);
        chk("rst_f_ne",   bus_f.ne,   1);
        rst_n = 1'b1;
        tick(); tick();

        // ---------------- write, default timing ----------------
        a0 = ack_d;
        start_d(1'b1, 19'h5_1234, 16'hBEEF);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("wr_nadv_c%0d", k), bus_d.nadv,  (k <= 2) ? 0 : 1);
            chk($sformatf("wr_ne_c%0d", k),   bus_d.ne,    (k <= 7) ? 0 : 1);
            chk($sformatf("wr_nwe_c%0d", k),  bus_d.nwe,   (k >= 4 && k <= 7) ? 0 : 1);
            chk($sformatf("wr_noe_c%0d", k),  bus_d.noe,   1);
            chk($sformatf("wr_ad_oe_c%0d", k), bus_d.ad_oe, (k <= 8) ? 1 : 0);
            chk($sformatf("wr_ack_c%0d", k),  bus_d.ack,   (k == 8) ? 1 : 0);
            chk($sformatf("wr_busy_c%0d", k), bus_d.busy,  (k <= 9) ? 1 : 0);
            if (k <= 3) chk($sformatf("wr_adaddr_c%0d", k), bus_d.ad_out, 32'h1234);
            if (k >= 4 && k <= 8) chk($sformatf("wr_addata_c%0d", k), bus_d.ad_out, 32'hBEEF);
            if (k <= 8) chk($sformatf("wr_a_hi_c%0d", k), bus_d.a_hi, 5);
            tick();
        end
        chk("wr_ack_count", ack_d - a0, 1);
        chk("wr_slave_mem", mem[4], 32'hBEEF);

        // ---------------- read, default timing ----------------
        a0 = ack_d;
        start_d(1'b0, 19'h2_0041, 16'hDEAD);
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("rd_noe_c%0d", k),   bus_d.noe,   (k >= 4 && k <= 7) ? 0 : 1);
            chk($sformatf("rd_nwe_c%0d", k),   bus_d.nwe,   1);
            chk($sformatf("rd_ad_oe_c%0d", k), bus_d.ad_oe, (k <= 3) ? 1 : 0);
            chk($sformatf("rd_ack_c%0d", k),   bus_d.ack,   (k == 8) ? 1 : 0);
            if (k <= 3) chk($sformatf("rd_adaddr_c%0d", k), bus_d.ad_out, 32'h0041);
            if (k <= 3) chk($sformatf("rd_a_hi_c%0d", k),   bus_d.a_hi,   2);
            if (k == 8) chk("rd_rdata_at_ack", bus_d.rdata, 32'hA55A);
            tick();
        end
        chk("rd_ack_count", ack_d - a0, 1);
        chk("rd_rdata_held", bus_d.rdata, 32'hA55A);

        // ---------------- minimum timing, back-to-back ----------------
        a0 = ack_f;
        bus_f.req = 1'b1; bus_f.wr = 1'b1; bus_f.addr = 19'h3_0010; bus_f.wdata = 16'h1111;
        tick();
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("ext_nadv_c%0d", k), bus_f.nadv, (k == 1 || k == 6) ? 0 : 1);
            chk($sformatf("ext_ne_c%0d", k),   bus_f.ne,   (k <= 3 || (k >= 6 && k <= 8)) ? 0 : 1);
            chk($sformatf("ext_nwe_c%0d", k),  bus_f.nwe,  (k == 3 || k == 8) ? 0 : 1);
            chk($sformatf("ext_ack_c%0d", k),  bus_f.ack,  (k == 4 || k == 9) ? 1 : 0);
            chk($sformatf("ext_busy_c%0d", k), bus_f.busy, (k == 5 || k == 10) ? 0 : 1);
            if (k == 3) chk("ext_ad_data", bus_f.ad_out, 32'h1111);
            if (k == 1) chk("ext_a_hi", bus_f.a_hi, 3);
            if (k == 6) bus_f.req = 1'b0;
            tick();
        end
        chk("ext_ack_count", ack_f - a0, 2);

        // ---------------- reset during DATA of a write ----------------
        start_d(1'b1, 19'h0_0007, 16'h7777);
        tick(); tick(); tick(); tick();
        chk("rstmid_in_data_nwe", bus_d.nwe, 0);
        rst_n = 1'b0;
        tick();
        chk_reset_d("rstmid");
        a0 = ack_d;
        rst_n = 1'b1;
        bus_d.req = 1'b1; bus_d.wr = 1'b1; bus_d.addr = 19'h0_0003; bus_d.wdata = 16'h3333;
        tick();
        chk("rstmid_first_cycle_ignored", bus_d.busy, 0);
        tick();
        chk("rstmid_fresh_accepted", bus_d.busy, 1);
        bus_d.req = 1'b0;
        for (int j = 2; j <= 10; j++) begin
            tick();
            if (j == 8) chk("rstmid_fresh_ack", bus_d.ack, 1);
            if (j == 8) chk("rstmid_fresh_data", bus_d.ad_out, 32'h3333);
        end
        chk("rstmid_ack_count", ack_d - a0, 1);
        chk("rstmid_slave_mem", mem[3], 32'h3333);

        // ---------------- REQ toggling while busy ----------------
        a0 = ack_d;
        start_d(1'b0, 19'h5_4321, 16'h0000);
        for (int k = 1; k <= 10; k++) begin
            if (k <= 3) chk($sformatf("tog_adaddr_c%0d", k), bus_d.ad_out, 32'h4321);
            if (k <= 3) chk($sformatf("tog_a_hi_c%0d", k),   bus_d.a_hi,   5);
            if (k >= 4 && k <= 7) chk($sformatf("tog_nwe_c%0d", k), bus_d.nwe, 1);
            chk($sformatf("tog_ack_c%0d", k), bus_d.ack, (k == 8) ? 1 : 0);
            if (k <= 7) begin
                bus_d.req  = k[0];
                bus_d.wr   = 1'b1;
                bus_d.addr = k[0] ? 19'h7_FFFF : 19'h1_0000;
            end else begin
                bus_d.req = 1'b0;
            end
            tick();
        end
        chk("tog_ack_count", ack_d - a0, 1);
        chk("tog_idle_after", bus_d.busy, 0);

        // ---------------- loop-back through the slave model ----------------
        start_d(1'b1, 19'h5_0000, 16'h1357);
        for (int j = 1; j <= 10; j++) tick();
        start_d(1'b0, 19'h5_0000, 16'h0000);
        for (int j = 2; j <= 8; j++) tick();
        chk("loop_ack", bus_d.ack, 1);
        chk("loop_rdata", bus_d.rdata, 32'h1357);
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsmc_mux_master.md
FSMC_MUX_MASTER -- requirements
Module: fsmc_mux_master

Interface
REQ-001 Parameter ADDSET, 2: address-setup cycles with NADV low, legal range 1..15.
REQ-002 Parameter ADDHLD, 1: address-hold cycles after the NADV rise, legal range 1..15.
REQ-003 Parameter DATAST, 4: data-strobe cycles with NOE or NWE low, legal range 1..255.
REQ-004 Parameter BUSTURN, 1: idle turnaround cycles after a transaction, legal range 0..15.
REQ-005 CLK  in  1  sole clock; all outputs are registered on its rising edge.
REQ-006 RST_N  in  1  reset, synchronous and active-low.
REQ-007 REQ  in  1  transaction request, sampled only in IDLE.
REQ-008 WR  in  1  1 = write, 0 = read; captured with REQ.
REQ-009 ADDR  in  19  transaction address; captured with REQ.
REQ-010 WDATA  in  16  write data; captured with REQ.
REQ-011 BUSY  out  1  high whenever the state is not IDLE.
REQ-012 ACK  out  1  one-cycle pulse marking transaction completion.
REQ-013 RDATA  out  16  read data; valid from the ACK cycle until the next read's ACK.
REQ-014 NE  out  1  chip enable, active-low.
REQ-015 NADV  out  1  address-valid strobe, active-low; the far end latches the address on its rising edge.
REQ-016 NOE, NWE  out  1 each  read strobe and write strobe, active-low.
REQ-017 A_HI  out  3  address bits [18:16] (A16..A18).
REQ-018 AD_OUT  out  16  multiplexed address/data drive value.
REQ-019 AD_OE  out  1  tristate enable for AD_OUT; the pad buffer lives at top level.
REQ-020 AD_IN  in  16  multiplexed bus value as read back from the pad.

Function
REQ-021 FSM states SHALL be IDLE, ASET, AHLD, DATA, ENDC and TURN.
REQ-022 IDLE: on REQ=1, the block SHALL capture WR, ADDR and WDATA and enter ASET on the next edge; REQ=0 SHALL leave the FSM in IDLE.
REQ-023 ASET, ADDSET cycles: NE=0, NADV=0, AD_OE=1, AD_OUT=ADDR[15:0], A_HI=ADDR[18:16].
REQ-024 AHLD, ADDHLD cycles: NADV=1; NE, AD_OUT, AD_OE and A_HI unchanged from ASET.
REQ-025 DATA on write, DATAST cycles: NWE=0, AD_OE=1, AD_OUT=WDATA.
REQ-026 DATA on read, DATAST cycles: NOE=0, AD_OE=0.
REQ-027 Read sampling: RDATA SHALL take AD_IN on the clock edge that ends the last DATA cycle.
REQ-028 ENDC, exactly 1 cycle: NE=1, NOE=1, NWE=1, ACK=1.
REQ-029 ENDC on write: AD_OUT=WDATA, AD_OE=1 and A_HI SHALL be held, giving data hold across the NWE rise.
REQ-030 ENDC on read: AD_OE=0.
REQ-031 TURN, BUSTURN cycles: AD_OE=0 and all strobes high; BUSTURN=0 SHALL skip TURN and go ENDC->IDLE.
REQ-032 Latency: ACK SHALL be high exactly 1+ADDSET+ADDHLD+DATAST cycles after the REQ-accept edge.
REQ-033 Inter-transaction gap: the next REQ SHALL be accepted no earlier than BUSTURN+1 cycles after ACK.
REQ-034 REQ while BUSY=1 SHALL be ignored, not queued; captured fields SHALL NOT change mid-transaction.
REQ-035 NADV, NOE and NWE SHALL never be low simultaneously.
REQ-036 NOE and NWE SHALL be low only while NE=0.
REQ-037 Phase counter: 8 bits, loaded with the phase length minus 1 on phase entry, phase exits at 0; no wrap occurs.
REQ-038 ACK SHALL occur exactly once per accepted request.

Reset
REQ-039 RST_N=0 at a clock edge SHALL force: state IDLE, NE/NADV/NOE/NWE=1, AD_OE=0, AD_OUT=0, A_HI=0, ACK=0, RDATA=0, BUSY=0.
REQ-040 Reset mid-transaction SHALL abort it with no ACK; REQ is not accepted in the first cycle after RST_N rises, since BUSY=0 but the FSM is only then leaving reset.

Structure
REQ-041 Package fsmc_pkg SHALL hold the state encoding, the AD/address width constants and the default timing constants.
REQ-042 Sub-module fsmc_phase_cnt SHALL implement the load/decrement/zero-flag counter; the FSM stays in fsmc_mux_master.

Verification
REQ-043 Write test: defaults, write ADDR=0x5_1234, WDATA=0xBEEF.
- Expect A_HI=5 and AD_OUT=0x1234 while NADV is low for 2 cycles.
- Expect AD_OUT=0xBEEF while NWE is low for 4 cycles, held through ENDC.
- Expect ACK at cycle 8.
REQ-044 Read test: defaults, read with a model driving AD_IN=0xA55A during DATA.
- Expect NOE low for 4 cycles and AD_OE=0 throughout DATA.
- Expect RDATA=0xA55A at ACK.
REQ-045 Timing extremes: ADDSET=1, ADDHLD=1, DATAST=1, BUSTURN=0.
- Expect ACK at cycle 4.
- Back-to-back REQ: second NE fall 2 cycles after the first ACK.
REQ-046 RST_N pulled low during DATA of a write: all outputs at reset values next edge, no ACK, a fresh request afterwards completes normally.
REQ-047 REQ toggled every cycle while BUSY: exactly one ACK per accepted request, captured ADDR unchanged during the transaction.
REQ-048 Loop-back against the team's FSMC slave buffer model: write 0x1357 to 0x5_0000 then read the same address; expect RDATA=0x1357.
